// File: rtl/fft_result_capture_if.sv
// FFT source-stream bundle: the FFT drives data/framing, the capture sink drives ready.
interface fft_result_capture_if #(
  parameter int DATA_W = 16
);
  logic                     fft_src_valid;
  logic                     fft_src_sop;
  logic                     fft_src_eop;
  logic signed [DATA_W-1:0] fft_src_real;
  logic signed [DATA_W-1:0] fft_src_imag;
  logic                     fft_src_ready;

  modport master (
    output fft_src_valid, fft_src_sop, fft_src_eop, fft_src_real, fft_src_imag,
    input  fft_src_ready
  );
  modport slave (
    input  fft_src_valid, fft_src_sop, fft_src_eop, fft_src_real, fft_src_imag,
    output fft_src_ready
  );
endinterface

// File: rtl/fft_result_capture.sv
// FFT output sink: checks frame framing, stores |re|+|im| of the lower half-spectrum
// into a ping-pong buffer and hands completed frames to the LCD renderer.
module fft_result_capture #(
  parameter int N_POINTS = 128,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  fft_result_capture_if.slave src,
  input  logic                disp_busy,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W:0]     rd_data,
  output logic                frame_done,
  output logic                frame_err,
  output logic [7:0]          drop_cnt
);
  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mre;
    logic [DATA_W-1:0] mim;
  } s1_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N_POINTS-1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);

  state_t          state, state_nxt;
  logic [ADDR_W:0] cnt, cnt_nxt, idx;
  logic            run_q, wr_bank, have_frame;
  logic            acc, take, swap, drop;
  s1_t             s1;
  logic [DATA_W:0] mem [N_POINTS];

  // Unsigned magnitude; the most negative input maps to 2^(DATA_W-1) exactly.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    mag = x[DATA_W-1] ? -x : x;
  endfunction

  assign src.fft_src_ready = run_q && (state != COMMIT);
  assign acc               = src.fft_src_valid && src.fft_src_ready;
  assign frame_done        = swap;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx       = '0;
    take      = 1'b0;
    frame_err = 1'b0;
    swap      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (acc && src.fft_src_sop) begin
        if (src.fft_src_eop) frame_err = 1'b1;
        else begin
          take      = 1'b1;
          cnt_nxt   = ONE;
          state_nxt = RECV;
        end
      end
      RECV: if (acc) begin
        if (src.fft_src_sop) begin
          frame_err = 1'b1;
          if (src.fft_src_eop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            take    = 1'b1;
            cnt_nxt = ONE;
          end
        end else begin
          take = 1'b1;
          idx  = cnt;
          if (src.fft_src_eop && cnt == LAST) begin
            state_nxt = COMMIT;
            cnt_nxt   = '0;
          end else if (src.fft_src_eop || cnt == LAST) begin
            frame_err = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + ONE;
        end
      end
      COMMIT: begin
        // Two drain cycles, then the swap/drop decision in the third.
        if (cnt == TWO) begin
          swap      = !disp_busy;
          drop      = disp_busy;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + ONE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      run_q      <= 1'b0;
      wr_bank    <= 1'b0;
      have_frame <= 1'b0;
      drop_cnt   <= '0;
      s1         <= '0;
      rd_data    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      run_q    <= 1'b1;
      s1.vld   <= take && !idx[ADDR_W];
      s1.addr  <= idx[ADDR_W-1:0];
      s1.mre   <= mag(src.fft_src_real);
      s1.mim   <= mag(src.fft_src_imag);
      if (swap) begin
        wr_bank    <= ~wr_bank;
        have_frame <= 1'b1;
      end
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      // Display bank is always the one not being written.
      rd_data <= have_frame ? mem[{~wr_bank, rd_addr}] : '0;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (s1.vld) mem[{wr_bank, s1.addr}] <= {1'b0, s1.mre} + {1'b0, s1.mim};
  end
endmodule
